// File: rtl/multiplier_input_conditioner_if.sv
// Raw push-button / switch inputs and their conditioned levels for the
// Lab5 multiplier front end. The slave modport is the conditioner side.
interface multiplier_input_conditioner_if #(
   parameter int WIDTH = 8
);
   logic             Run_btn_n;
   logic             ClearLoad_btn_n;
   logic [WIDTH-1:0] SW;
   logic             Run;
   logic             ClearA_LoadB;
   logic             Run_pulse;
   logic [WIDTH-1:0] S;

   modport master (
      output Run_btn_n, ClearLoad_btn_n, SW,
      input  Run, ClearA_LoadB, Run_pulse, S
   );

   modport slave (
      input  Run_btn_n, ClearLoad_btn_n, SW,
      output Run, ClearA_LoadB, Run_pulse, S
   );
endinterface

// File: rtl/multiplier_input_conditioner.sv
// Synchronizes and debounces the active-low Run and Clear/Load keys and
// synchronizes the operand switches for the shift-add multiplier.
module multiplier_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SYNC_STAGES     = 2,
   parameter int WIDTH           = 8
) (
   input  logic Clk,
   input  logic Reset,
   multiplier_input_conditioner_if.slave bus
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] run_sync;
   logic [SYNC_STAGES-1:0] clr_sync;
   logic [WIDTH-1:0]       sw_sync [SYNC_STAGES];

   // Channel 0 is Run, channel 1 is Clear A / Load B.
   logic [1:0]    pressed;
   logic [1:0]    deb;
   logic [1:0]    deb_nxt;
   logic [CW-1:0] cnt     [2];
   logic [CW-1:0] cnt_nxt [2];
   logic          run_prev;
   logic          run_pulse_q;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         run_sync <= '1;
         clr_sync <= '1;
         for (int i = 0; i < SYNC_STAGES; i++) sw_sync[i] <= '0;
      end else begin
         run_sync   <= {run_sync[SYNC_STAGES-2:0], bus.Run_btn_n};
         clr_sync   <= {clr_sync[SYNC_STAGES-2:0], bus.ClearLoad_btn_n};
         sw_sync[0] <= bus.SW;
         for (int i = 1; i < SYNC_STAGES; i++) sw_sync[i] <= sw_sync[i-1];
      end
   end

   assign pressed = ~{clr_sync[SYNC_STAGES-1], run_sync[SYNC_STAGES-1]};

   // Any sample agreeing with the current level restarts the stability count.
   always_comb begin
      deb_nxt = deb;
      for (int ch = 0; ch < 2; ch++) begin
         cnt_nxt[ch] = cnt[ch];
         if (pressed[ch] == deb[ch]) begin
            cnt_nxt[ch] = '0;
         end else if (cnt[ch] == CNT_LAST) begin
            deb_nxt[ch] = ~deb[ch];
            cnt_nxt[ch] = '0;
         end else begin
            cnt_nxt[ch] = cnt[ch] + CW'(1);
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         deb         <= '0;
         cnt[0]      <= '0;
         cnt[1]      <= '0;
         run_prev    <= 1'b0;
         run_pulse_q <= 1'b0;
      end else begin
         deb         <= deb_nxt;
         cnt[0]      <= cnt_nxt[0];
         cnt[1]      <= cnt_nxt[1];
         run_prev    <= deb[0];
         run_pulse_q <= deb[0] & ~run_prev;
      end
   end

   assign bus.Run          = deb[0];
   assign bus.ClearA_LoadB = deb[1];
   assign bus.Run_pulse    = run_pulse_q;
   assign bus.S            = sw_sync[SYNC_STAGES-1];
endmodule

// File: tb/tb_multiplier_input_conditioner.sv
// Bench for multiplier_input_conditioner: directed plan scenarios plus
// random bounce traffic, checked every cycle against a window-based model.
module tb_multiplier_input_conditioner;
   localparam int D  = 4;
   localparam int NS = 2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   multiplier_input_conditioner_if #(.WIDTH(8)) cond_if ();
   multiplier_input_conditioner_if #(.WIDTH(8)) cond_if_def ();

   multiplier_input_conditioner #(
      .DEBOUNCE_CYCLES(D), .SYNC_STAGES(NS), .WIDTH(8)
   ) dut (
      .Clk(clk), .Reset(rst_n), .bus(cond_if)
   );

   multiplier_input_conditioner dut_default (
      .Clk(clk), .Reset(rst_n), .bus(cond_if_def)
   );

   int n_checks = 0;
   int n_errors = 0;
   bit scb_en   = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: each synchronizer is a plain delay line; a level flips once the
   // last D synced samples all disagree with it.
   bit         run_pipe[$];
   bit         clr_pipe[$];
   logic [7:0] exp_q[$];
   bit         run_win[$];
   bit         clr_win[$];
   bit         m_run, m_clr, m_run_prev, m_pulse;
   logic [7:0] m_s;

   task automatic model_reset();
      run_pipe = {};
      clr_pipe = {};
      exp_q    = {};
      run_win  = {};
      clr_win  = {};
      for (int i = 0; i < NS; i++) begin
         run_pipe.push_back(1'b1);
         clr_pipe.push_back(1'b1);
         exp_q.push_back(8'h00);
      end
      for (int i = 0; i < D; i++) begin
         run_win.push_back(1'b0);
         clr_win.push_back(1'b0);
      end
      m_run = 0; m_clr = 0; m_run_prev = 0; m_pulse = 0; m_s = 8'h00;
   endtask

   task automatic model_step();
      bit all_r;
      bit all_c;
      bit new_run;
      bit new_clr;
      all_r = 1'b1;
      all_c = 1'b1;
      foreach (run_win[i]) if (run_win[i] == m_run) all_r = 1'b0;
      foreach (clr_win[i]) if (clr_win[i] == m_clr) all_c = 1'b0;
      new_run    = all_r ? !m_run : m_run;
      new_clr    = all_c ? !m_clr : m_clr;
      m_pulse    = m_run && !m_run_prev;
      m_run_prev = m_run;
      m_run      = new_run;
      m_clr      = new_clr;
      run_pipe.push_back(cond_if.Run_btn_n);
      void'(run_pipe.pop_front());
      clr_pipe.push_back(cond_if.ClearLoad_btn_n);
      void'(clr_pipe.pop_front());
      exp_q.push_back(cond_if.SW);
      void'(exp_q.pop_front());
      m_s = exp_q[0];
      run_win.push_back(!run_pipe[0]);
      void'(run_win.pop_front());
      clr_win.push_back(!clr_pipe[0]);
      void'(clr_win.pop_front());
   endtask

   // One clock: model updates on the rising edge, outputs compared on the falling edge.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) model_reset();
      else model_step();
      @(negedge clk);
      if (scb_en) begin
         chk("sb_run", cond_if.Run, m_run);
         chk("sb_clr", cond_if.ClearA_LoadB, m_clr);
         chk("sb_pulse", cond_if.Run_pulse, m_pulse);
         chk("sb_s", cond_if.S, m_s);
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic release_buttons();
      cond_if.Run_btn_n       = 1'b1;
      cond_if.ClearLoad_btn_n = 1'b1;
      ticks(12);
   endtask

   initial begin
      bit b3[8];
      bit b4[6];
      int n_pulses;
      int run_hold;
      int clr_hold;

      rst_n                       = 1'b0;
      cond_if.Run_btn_n           = 1'b0;
      cond_if.ClearLoad_btn_n     = 1'b0;
      cond_if.SW                  = 8'hA5;
      cond_if_def.Run_btn_n       = 1'b1;
      cond_if_def.ClearLoad_btn_n = 1'b1;
      cond_if_def.SW              = 8'h00;
      model_reset();
      @(negedge clk);

      // 1: reset values, then switch latency
      ticks(2);
      chk("t1_run", cond_if.Run, 1'b0);
      chk("t1_clr", cond_if.ClearA_LoadB, 1'b0);
      chk("t1_pulse", cond_if.Run_pulse, 1'b0);
      chk("t1_s", cond_if.S, 8'h00);
      rst_n = 1'b1;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (e == 1) chk("t1_s_e1", cond_if.S, 8'h00);
         if (e == 2) chk("t1_s_e2", cond_if.S, 8'hA5);
      end
      release_buttons();

      // 2: clean press and release
      cond_if.Run_btn_n = 1'b0;
      for (int e = 1; e <= 30; e++) begin
         tick();
         if (e == 5) chk("t2_run_e5", cond_if.Run, 1'b0);
         if (e == 6) chk("t2_run_e6", cond_if.Run, 1'b1);
         if (e == 6) chk("t2_pulse_e6", cond_if.Run_pulse, 1'b0);
         if (e == 7) chk("t2_pulse_e7", cond_if.Run_pulse, 1'b1);
         if (e >= 8) chk("t2_pulse_low", cond_if.Run_pulse, 1'b0);
         if (e == 19) cond_if.Run_btn_n = 1'b1;
         if (e == 24) chk("t2_run_e24", cond_if.Run, 1'b1);
         if (e == 25) chk("t2_run_e25", cond_if.Run, 1'b0);
      end
      release_buttons();

      // 3: bounce rejection
      b3 = '{0, 0, 0, 1, 0, 0, 0, 1};
      for (int e = 1; e <= 20; e++) begin
         cond_if.Run_btn_n = (e <= 8) ? b3[e-1] : 1'b1;
         tick();
         chk("t3_run", cond_if.Run, 1'b0);
         chk("t3_pulse", cond_if.Run_pulse, 1'b0);
      end
      release_buttons();

      // 4: bounce then settle on Clear/Load
      b4 = '{0, 1, 0, 0, 0, 0};
      for (int e = 1; e <= 14; e++) begin
         cond_if.ClearLoad_btn_n = (e <= 6) ? b4[e-1] : 1'b0;
         tick();
         if (e == 7) chk("t4_clr_e7", cond_if.ClearA_LoadB, 1'b0);
         if (e == 8) chk("t4_clr_e8", cond_if.ClearA_LoadB, 1'b1);
         chk("t4_run", cond_if.Run, 1'b0);
      end
      release_buttons();

      // 5: simultaneous press, then reset while held
      cond_if.Run_btn_n       = 1'b0;
      cond_if.ClearLoad_btn_n = 1'b0;
      for (int e = 1; e <= 10; e++) begin
         tick();
         if (e == 5) chk("t5_both_e5", {cond_if.Run, cond_if.ClearA_LoadB}, 2'b00);
         if (e == 6) chk("t5_both_e6", {cond_if.Run, cond_if.ClearA_LoadB}, 2'b11);
      end
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("t5_rst_outs", {cond_if.Run, cond_if.ClearA_LoadB, cond_if.Run_pulse}, 3'b000);
      tick();
      rst_n = 1'b1;
      n_pulses = 0;
      for (int f = 1; f <= 14; f++) begin
         tick();
         if (cond_if.Run_pulse) n_pulses++;
         if (f == 5) chk("t5_post_f5", {cond_if.Run, cond_if.ClearA_LoadB}, 2'b00);
         if (f == 6) chk("t5_post_f6", {cond_if.Run, cond_if.ClearA_LoadB}, 2'b11);
         if (f == 7) chk("t5_pulse_f7", cond_if.Run_pulse, 1'b1);
      end
      chk("t5_pulse_count", n_pulses, 1);
      release_buttons();

      // Random bounce traffic with occasional resets
      run_hold = 0;
      clr_hold = 0;
      for (int c = 0; c < 800; c++) begin
         if (run_hold == 0) begin
            cond_if.Run_btn_n = 1'($urandom_range(0, 1));
            run_hold = $urandom_range(1, 7);
         end
         if (clr_hold == 0) begin
            cond_if.ClearLoad_btn_n = 1'($urandom_range(0, 1));
            clr_hold = $urandom_range(1, 7);
         end
         run_hold--;
         clr_hold--;
         cond_if.SW = 8'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            chk("rnd_rst_outs", {cond_if.Run, cond_if.ClearA_LoadB, cond_if.Run_pulse, cond_if.S}, 11'h0);
            tick();
            rst_n = 1'b1;
         end
         tick();
      end
      release_buttons();

      // 6: default parameters, held press
      scb_en = 1'b0;
      cond_if_def.Run_btn_n = 1'b0;
      for (int e = 1; e <= 50004; e++) begin
         tick();
         if (e == 50001) chk("t6_run_e50001", cond_if_def.Run, 1'b0);
         if (e == 50002) chk("t6_run_e50002", cond_if_def.Run, 1'b1);
         if (e == 50002) chk("t6_pulse_e50002", cond_if_def.Run_pulse, 1'b0);
         if (e == 50003) chk("t6_pulse_e50003", cond_if_def.Run_pulse, 1'b1);
      end
      chk("t6_clr", cond_if_def.ClearA_LoadB, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/multiplier_input_conditioner.md
# multiplier_input_conditioner

Front-end input stage for the Lab5 shift-add multiplier. It synchronizes and debounces the two raw active-low push-buttons (Run, Clear/Load) and synchronizes the 8-bit operand switches. The clean, active-high levels it produces drive the multiplier control FSM's Run and ClearA_LoadB inputs; S feeds the datapath. A one-cycle Run_pulse is provided for auxiliary logic such as cycle counters and display latches.

## Interface
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a debounced level changes (1 ms at 50 MHz); legal range ≥ 1
- SYNC_STAGES, 2, synchronizer flop depth for every raw input; legal range ≥ 2
- WIDTH, 8, switch/operand width
- Clk  input  1  system clock; all state updates on its rising edge
- Reset  input  1  asynchronous, active-low reset
- Run_btn_n  input  1  raw Run key, low = pressed, asynchronous to Clk
- ClearLoad_btn_n  input  1  raw Clear A / Load B key, low = pressed, asynchronous to Clk
- SW  input  WIDTH  raw operand switches, asynchronous to Clk
- Run  output  1  debounced Run level, high = pressed
- ClearA_LoadB  output  1  debounced Clear/Load level, high = pressed
- Run_pulse  output  1  high for exactly one cycle on each debounced Run rising edge
- S  output  WIDTH  synchronized switch value

## Operation
- **Synchronizers.** Each button passes through SYNC_STAGES flops, reset value 1 (released). Each SW bit passes through SYNC_STAGES flops, reset value 0. The last stage is the "synced" value. S equals the synced SW value; no debounce is applied to SW.
- **Per-button debounce state.** Each button has:
  - a 1-bit debounced level `deb`, reset 0 = released, active-high;
  - a counter of width clog2(DEBOUNCE_CYCLES+1), reset 0.
- **Debounce rule, evaluated every edge.** Compare the inverted synced value (pressed = 1) against `deb`:
  - equal: counter ← 0;
  - differ, counter = DEBOUNCE_CYCLES−1: `deb` toggles and counter ← 0 on the same edge;
  - differ otherwise: counter increments.
- **Glitch rejection.** Any single-cycle return to the current `deb` value restarts the count from 0.
- **Channel independence.**
  - The two button channels are fully independent. Both may be high at once; this block does not arbitrate, because the control FSM gives Run priority.
  - Run and ClearA_LoadB are registered `deb` outputs.
- **Run_pulse.** Registered: high in the cycle after Run goes 0→1, for one cycle. It does not reassert while Run stays high, and it never fires on Run falling.
- **Reset assertion.**
  - Takes effect immediately, asynchronously, including mid-count or mid-bounce. All outputs go to 0, counters to 0, and synchronizers to their reset values.
  - A button held through reset release is detected as a fresh press after the full latency.
- **Counter overflow.** Impossible: the counter never exceeds DEBOUNCE_CYCLES−1.

## Timing
- **Button latency.** A clean raw transition first sampled at rising edge 1 changes Run / ClearA_LoadB after edge SYNC_STAGES+DEBOUNCE_CYCLES. With the defaults this is 50002 cycles.
- **Run_pulse** is asserted one cycle later, during the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- **Switch latency.** S reflects SW after SYNC_STAGES edges (2 cycles).
- **Bounces.** Raw pulses shorter than DEBOUNCE_CYCLES cycles, as seen at the synchronizer output, never change outputs.
- **Release timing.** Release uses the same latency as press.
- **Output glitches.** All outputs come from flops; none are combinational.

## Test plan
Use DEBOUNCE_CYCLES=4 and SYNC_STAGES=2 unless noted.
1. **Reset values.** Drive Reset=0 with buttons pressed and SW=8'hA5 → Run=0, ClearA_LoadB=0, Run_pulse=0, S=8'h00 while Reset is low. After release with SW=8'hA5 held → S=8'hA5 after edge 2.
2. **Clean press/release.** Run_btn_n goes to 0 before edge 1 and is held →
   - Run=1 after edge 6;
   - Run_pulse=1 only in the cycle after edge 7;
   - Run_btn_n returning to 1 before edge 20 → Run=0 after edge 25, with no Run_pulse.
3. **Bounce rejection.** Run_btn_n pattern 0,0,0,1,0,0,0,1 (one value per cycle), then held at 1 → Run stays 0 and Run_pulse stays 0 throughout.
4. **Bounce then settle.** ClearLoad_btn_n pattern 0,1,0,0,0,0 then held at 0 → ClearA_LoadB rises exactly 4 stable synced cycles after the last 1 clears the synchronizer. Run is unaffected.
5. **Simultaneous press and mid-operation reset.**
   - Both buttons pressed on the same cycle → Run and ClearA_LoadB rise on the same edge.
   - Reset pulsed low for 1 cycle with the buttons held → both outputs drop to 0 immediately, then both rise again 6 edges after reset release.
   - Exactly one Run_pulse is produced after the reset.
6. **Default-parameter sanity.** DEBOUNCE_CYCLES=50000 with a held press → Run rises after edge 50002, not after edge 50001.
